// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food placement FSM state type.
package snake_pkg;
  localparam int GRID_BITS = 6;
  localparam int POS_W     = 7;
  localparam int CELLS     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/food_generator_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, reloads seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] q_reg;
  logic        fb;

  // Right-shifting form: tap k lives in bit 16-k.
  assign fb = q_reg[0] ^ q_reg[2] ^ q_reg[3] ^ q_reg[5];
  assign q  = q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= seed;
    end else begin
      q_reg <= {fb, q_reg[15:1]};
    end
  end
endmodule

// File: rtl/food_generator.sv
// Food placement: random candidate from an LFSR, linear probe past occupied cells.
// FOOD_OCC_CHECK_EN enables the body-occupancy probe (occ_addr / occ_hit).
module food_generator
  import snake_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gen,
  input  logic [POS_W-1:0]     head,
  input  logic                 occ_hit,
  output logic [GRID_BITS-1:0] occ_addr,
  output logic [POS_W-1:0]     food,
  output logic                 busy,
  output logic                 board_full
);
  logic [15:0]          lfsr_q;
  state_t               state_reg, state_next;
  logic [GRID_BITS-1:0] cand_reg, cand_next;
  logic [GRID_BITS:0]   probe_reg, probe_next;
  logic [POS_W-1:0]     food_reg, food_next;
  logic                 busy_reg, busy_next;
  logic                 full_reg, full_next;
  logic                 occupied;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

`ifdef FOOD_OCC_CHECK_EN
  logic unused_bits;
  assign unused_bits = ^{head[6], lfsr_q[15:6]};
  assign occupied    = (cand_reg == head[5:0]) || occ_hit;
  assign occ_addr    = (state_reg == CHECK) ? cand_reg : '0;
`else
  logic unused_bits;
  assign unused_bits = ^{occ_hit, head[6], lfsr_q[15:6]};
  assign occupied    = (cand_reg == head[5:0]);
  assign occ_addr    = '0;
`endif

  assign food       = food_reg;
  assign busy       = busy_reg;
  assign board_full = full_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cand_reg  <= '0;
      probe_reg <= '0;
      food_reg  <= '0;
      busy_reg  <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      probe_reg <= probe_next;
      food_reg  <= food_next;
      busy_reg  <= busy_next;
      full_reg  <= full_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    probe_next = probe_reg;
    food_next  = food_reg;
    busy_next  = busy_reg;
    full_next  = full_reg;
    case (state_reg)
      IDLE: begin
        if (gen) begin
          cand_next    = lfsr_q[GRID_BITS-1:0];
          food_next[6] = 1'b0;
          probe_next   = '0;
          busy_next    = 1'b1;
          state_next   = CHECK;
        end
      end
      CHECK: begin
        if (!occupied) begin
          food_next  = {1'b1, cand_reg};
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cand_next  = cand_reg + 6'd1;
          probe_next = probe_reg + 7'd1;
          // The 64th occupied probe means every cell has been tried.
          if (probe_reg == 7'(CELLS - 1)) begin
            full_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = FULL;
          end
        end
      end
      FULL: begin
        state_next = FULL;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_food_generator.sv
// Directed bench for food_generator with a food scoreboard and an LFSR reference model.
module tb_food_generator;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       gen = 1'b0;
  logic [6:0] head = 7'h00;
  logic       occ_hit = 1'b0;
  logic [5:0] occ_addr;
  logic [6:0] food;
  logic       busy;
  logic       board_full;

  localparam logic [15:0] SEED = 16'hACE1;

  int checks = 0;
  int errors = 0;
  logic [6:0]  exp_q[$];
  logic [15:0] model;
  logic [5:0]  c;

  food_generator #(.LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .gen        (gen),
    .head       (head),
    .occ_hit    (occ_hit),
    .occ_addr   (occ_addr),
    .food       (food),
    .busy       (busy),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  // Reference LFSR: feedback is the parity of tap bits 0,2,3,5 (taps 16,14,13,11).
  always @(posedge clk or negedge rst) begin
    if (!rst) model <= SEED;
    else      model <= {^(model & 16'h002D), model[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    gen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_food(input string tag, input int lat_exp);
    int lat;
    logic [6:0] e;
    lat = 1;
    while (busy === 1'b1 && lat <= 70) begin
      tick();
      lat++;
    end
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_latency"}, lat, lat_exp);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_food"}, food, e);
      $display("txn %s food=%02h expected=%02h latency=%0d", tag, food, e, lat);
    end
  endtask

  // Issue one request with a fixed head; the expected cell comes from the model.
  task automatic request(input string tag, input logic [6:0] h);
    logic [5:0] cc;
    logic [5:0] ec;
    int le;
    head = h;
    cc = model[5:0];
    ec = (cc == h[5:0]) ? cc + 6'd1 : cc;
    le = (cc == h[5:0]) ? 3 : 2;
    exp_q.push_back({1'b1, ec});
    gen = 1'b1;
    tick();
    gen = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_valid_clr"}, food[6], 1'b0);
`ifdef FOOD_OCC_CHECK_EN
    check({tag, "_occ_addr"}, occ_addr, cc);
`else
    check({tag, "_occ_addr"}, occ_addr, 6'd0);
`endif
    wait_food(tag, le);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_food", food, 7'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_full", board_full, 1'b0);
    check("rst_occ_addr", occ_addr, 6'd0);

    // First-edge request, no collision
    reset_release();
    request("first_free", 7'h00);
    check("first_free_lit", food, 7'h61);

    // First-edge request, one head collision
    reset_release();
    request("first_hit", 7'h21);
    check("first_hit_lit", food, 7'h62);

    // Extra gen pulse while searching is ignored
    reset_release();
    head = 7'h21;
    gen = 1'b1;
    tick();
    tick();
    gen = 1'b0;
    tick();
    $display("txn regen food=%02h expected=62", food);
    check("regen_food", food, 7'h62);
    tick();
    tick();
    check("regen_busy_after", busy, 1'b0);
    check("regen_food_after", food, 7'h62);

    // Requests after the LFSR has advanced
    reset_release();
    repeat (37) tick();
    request("later_a", 7'h15);
    request("later_b", {1'b0, model[5:0]});
    repeat (5) tick();
    request("later_c", 7'h40);

    // Asynchronous reset during a search
    reset_release();
    request("pre_abort", 7'h21);
    head = 7'h21;
    gen = 1'b1;
    tick();
    gen = 1'b0;
    check("abort_busy_pre", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_food", food, 7'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_full", board_full, 1'b0);
    check("abort_occ_addr", occ_addr, 6'd0);

    // 63 occupied probes, then a free cell on the 65th edge (wraps past 63)
    reset_release();
    c = model[5:0];
    gen = 1'b1;
    tick();
    gen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      head = {1'b0, 6'(c + 6'(i))};
      tick();
    end
    head = {1'b0, 6'(c + 6'd62)};
    tick();
    $display("txn near_full food=%02h expected=%02h", food, {1'b1, 6'(c + 6'd63)});
    check("near_full_food", food, {1'b1, 6'(c + 6'd63)});
    check("near_full_busy", busy, 1'b0);
    check("near_full_flag", board_full, 1'b0);

    // 64 occupied probes by head tracking -> FULL
    reset_release();
    c = model[5:0];
    gen = 1'b1;
    tick();
    gen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      head = {1'b0, 6'(c + 6'(i))};
      tick();
      if (i == 62) begin
        check("full_not_yet", board_full, 1'b0);
        check("full_busy_63", busy, 1'b1);
      end
    end
    $display("txn board_full flag=%0b food=%02h", board_full, food);
    check("full_flag", board_full, 1'b1);
    check("full_busy", busy, 1'b0);
    check("full_valid", food[6], 1'b0);
    gen = 1'b1;
    tick();
    tick();
    gen = 1'b0;
    tick();
    check("full_sticky", board_full, 1'b1);
    check("full_gen_busy", busy, 1'b0);
    check("full_gen_valid", food[6], 1'b0);
    rst = 1'b0;
    #1;
    check("full_reset_clears", board_full, 1'b0);

`ifdef FOOD_OCC_CHECK_EN
    // occ_hit held high fills the board
    reset_release();
    occ_hit = 1'b1;
    head = 7'h00;
    gen = 1'b1;
    tick();
    gen = 1'b0;
    repeat (64) tick();
    $display("txn occ_full flag=%0b food=%02h", board_full, food);
    check("occ_full_flag", board_full, 1'b1);
    check("occ_full_valid", food[6], 1'b0);
    check("occ_full_busy", busy, 1'b0);
    gen = 1'b1;
    tick();
    gen = 1'b0;
    tick();
    check("occ_full_ignore", busy, 1'b0);
    occ_hit = 1'b0;
`else
    // occ_hit has no effect and occ_addr stays 0
    reset_release();
    occ_hit = 1'b1;
    head = 7'h00;
    gen = 1'b1;
    tick();
    gen = 1'b0;
    check("noocc_addr_1", occ_addr, 6'd0);
    check("noocc_busy", busy, 1'b1);
    tick();
    check("noocc_addr_2", occ_addr, 6'd0);
    $display("txn noocc food=%02h expected=61", food);
    check("noocc_food", food, 7'h61);
    occ_hit = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
